laser_pulse_monitor: RTL and testbench
======================================

Name: laser_pulse_monitor

Overview:
- Downstream consumer of the I2C register block's limit and control outputs; feeds its `monitor_status` readback (reg 0x1E).
- Samples the laser trigger pulse and measures each pulse's high width and its rising-edge-to-rising-edge period in `clk` cycles.
- Compares the measurements against the programmed limits and raises sticky faults that gate the laser driver.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `pulse_in` (minimum 2).
- ENABLE_BIT, 0, bit of `static_control` that enables monitoring.
- CLEAR_BIT, 0, bit of `dynamic_control` that clears sticky faults.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
- pulse_in  in  1  asynchronous laser trigger pulse.
- pulse_width_lower_limit  in  32  minimum legal high width, in clk cycles.
- pulse_width_upper_limit  in  32  maximum legal high width, in clk cycles.
- rate_lower_limit  in  32  minimum legal period between rising edges, in clk cycles.
- static_control  in  16  static control; bit ENABLE_BIT = monitor enable.
- dynamic_control  in  16  self-clearing control; bit CLEAR_BIT = fault clear.
- monitor_status  out  8  status byte (bit map below).
- fault  out  1  OR of the sticky faults; drives laser inhibit.
- last_width  out  32  last completed high width.
- last_period  out  32  last completed period.

Behaviour:
- Reset: all outputs 0, synchroniser 0, FSM in IDLE, counters 0.
- Sync: `pulse_s` = last synchroniser stage; `pulse_d` = `pulse_s` delayed one clk. `rise` = pulse_s & ~pulse_d; `fall` = ~pulse_s & pulse_d. Edge-to-flag latency is SYNC_STAGES+1 clks.
- enable = static_control[ENABLE_BIT]. enable=0 forces the FSM to IDLE and clears both counters. Sticky faults and last_* hold their values.
- clear = dynamic_control[CLEAR_BIT], level-sensitive. Each cycle it is high, it clears all three sticky flags. A fault detected in the same cycle wins (flag stays/goes 1).
- FSM states:
  - IDLE: on rise -> HIGH; width_cnt<=1, period_cnt<=1, no rate check (first pulse).
  - HIGH: width_cnt+1 and period_cnt+1 each cycle (both saturate at 32'hFFFF_FFFF).
    - On fall: last_width<=width_cnt; width_short<=1 if width_cnt < pulse_width_lower_limit; -> LOW.
    - Any cycle in HIGH with width_cnt >= pulse_width_upper_limit and pulse_s=1: width_long<=1 immediately. Do not wait for fall; this covers stuck-high.
  - LOW: period_cnt+1 each cycle.
    - On rise: last_period<=period_cnt; rate_fast<=1 if period_cnt < rate_lower_limit; period_cnt<=1, width_cnt<=1; -> HIGH.
- Width semantics:
  - width_cnt = number of cycles pulse_s has been high including the current cycle. Lower-limit check is exclusive, so width == lower is legal.
  - width_long fires on the cycle width reaches upper+1. A pulse of exactly upper cycles is legal.
- Saturated counters compare as 32'hFFFF_FFFF; no wrap-around.
- Misprogrammed limits (lower > upper) are not checked: every pulse faults, by design.
- fault = width_short | width_long | rate_fast, registered alongside the flags.
- monitor_status bit map:
  - [0] width_short
  - [1] width_long
  - [2] rate_fast
  - [3] fault
  - [4] pulse_s
  - [5] enable
  - [6] first pulse seen since enable (FSM != IDLE)
  - [7] 0
- Reset mid-pulse: immediate return to reset values. The next rise is treated as a first pulse.
- Disable mid-pulse: FSM to IDLE. A partial pulse produces no width or rate check.

Test Plan:
- Defaults (lower=256, upper=341, rate=77824), enable=1; pulses high 300 clks, period 80000 -> last_width=300, last_period=80000, fault=0, monitor_status=8'h70 while high / 8'h60 while low.
- Boundary widths: pulse of 256 -> no fault; pulse of 255 -> width_short=1, monitor_status[3:0]=4'b1001 at fall+SYNC_STAGES+1.
- Upper boundary: 341-clk pulse -> no fault. Pulse held high indefinitely -> width_long=1 exactly 342 cycles after pulse_s rises, before any fall.
- Rate: period 77823 -> rate_fast=1, last_period=77823. Period 77824 -> no fault. First pulse after enable is never rate-checked.
- Clear: with width_short set, dynamic_control=16'h0001 for 1 clk -> fault=0 next clk. Clear coincident with a 255-clk pulse fall -> width_short remains 1.
- Async rst low mid-pulse -> all outputs 0 within the reset assertion. After release, the first pulse is not rate-checked. Disable mid-pulse -> no flags set, last_width unchanged.

Source files
------------

// File: rtl/laser_pulse_monitor.sv
// Laser trigger pulse monitor: measures the high width and rise-to-rise period of the
// synchronised trigger, checks them against programmed limits, and raises sticky faults.
module laser_pulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int ENABLE_BIT  = 0,
  parameter int CLEAR_BIT   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pulse_in,
  input  logic [31:0] pulse_width_lower_limit,
  input  logic [31:0] pulse_width_upper_limit,
  input  logic [31:0] rate_lower_limit,
  input  logic [15:0] static_control,
  input  logic [15:0] dynamic_control,
  output logic [7:0]  monitor_status,
  output logic        fault,
  output logic [31:0] last_width,
  output logic [31:0] last_period
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pulse_d_q;
  logic                   enable_q;
  logic [31:0]            width_cnt_q, width_cnt_d;
  logic [31:0]            period_cnt_q, period_cnt_d;
  logic [31:0]            last_width_q, last_width_d;
  logic [31:0]            last_period_q, last_period_d;
  logic                   width_short_q, width_short_d;
  logic                   width_long_q, width_long_d;
  logic                   rate_fast_q, rate_fast_d;
  logic                   fault_q, fault_d;

  logic        pulse_s, rise, fall, enable, clear;
  logic [31:0] width_inc, period_inc;
  logic        unused_ctrl;

  assign unused_ctrl = ^{static_control, dynamic_control};

  assign pulse_s = sync_q[SYNC_STAGES-1];
  assign rise    = pulse_s & ~pulse_d_q;
  assign fall    = ~pulse_s & pulse_d_q;
  assign enable  = static_control[ENABLE_BIT];
  assign clear   = dynamic_control[CLEAR_BIT];

  // Counters saturate so a stuck line can never wrap back into the legal range.
  assign width_inc  = (&width_cnt_q)  ? width_cnt_q  : width_cnt_q + 32'd1;
  assign period_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 32'd1;

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], pulse_in};
    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    period_cnt_d  = period_cnt_q;
    last_width_d  = last_width_q;
    last_period_d = last_period_q;
    // Clear is applied first so a fault detected in the same cycle still sets its flag.
    width_short_d = clear ? 1'b0 : width_short_q;
    width_long_d  = clear ? 1'b0 : width_long_q;
    rate_fast_d   = clear ? 1'b0 : rate_fast_q;

    if (!enable) begin
      state_d      = IDLE;
      width_cnt_d  = 32'd0;
      period_cnt_d = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d      = HIGH;
            width_cnt_d  = 32'd1;
            period_cnt_d = 32'd1;
          end
        end
        HIGH: begin
          width_cnt_d  = width_inc;
          period_cnt_d = period_inc;
          if (fall) begin
            last_width_d = width_cnt_q;
            if (width_cnt_q < pulse_width_lower_limit) width_short_d = 1'b1;
            state_d = LOW;
          end
          // Flag over-width while still high so a stuck-high trigger is caught.
          if (pulse_s && (width_cnt_q >= pulse_width_upper_limit)) width_long_d = 1'b1;
        end
        LOW: begin
          period_cnt_d = period_inc;
          if (rise) begin
            last_period_d = period_cnt_q;
            if (period_cnt_q < rate_lower_limit) rate_fast_d = 1'b1;
            period_cnt_d = 32'd1;
            width_cnt_d  = 32'd1;
            state_d      = HIGH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    fault_d = width_short_d | width_long_d | rate_fast_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      sync_q        <= '0;
      pulse_d_q     <= 1'b0;
      enable_q      <= 1'b0;
      width_cnt_q   <= 32'd0;
      period_cnt_q  <= 32'd0;
      last_width_q  <= 32'd0;
      last_period_q <= 32'd0;
      width_short_q <= 1'b0;
      width_long_q  <= 1'b0;
      rate_fast_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      pulse_d_q     <= pulse_s;
      enable_q      <= enable;
      width_cnt_q   <= width_cnt_d;
      period_cnt_q  <= period_cnt_d;
      last_width_q  <= last_width_d;
      last_period_q <= last_period_d;
      width_short_q <= width_short_d;
      width_long_q  <= width_long_d;
      rate_fast_q   <= rate_fast_d;
      fault_q       <= fault_d;
    end
  end

  assign monitor_status = {1'b0, (state_q != IDLE), enable_q, pulse_s,
                           fault_q, rate_fast_q, width_long_q, width_short_q};
  assign fault       = fault_q;
  assign last_width  = last_width_q;
  assign last_period = last_period_q;

endmodule

// File: tb/tb_laser_pulse_monitor.sv
// Bench for laser_pulse_monitor: pulse-train vector table plus hand sequences for
// stuck-high, coincident clear, disable mid-pulse and reset mid-pulse.
module tb_laser_pulse_monitor;

  logic        clk;
  logic        rst;
  logic        pulse_in;
  logic [31:0] pulse_width_lower_limit;
  logic [31:0] pulse_width_upper_limit;
  logic [31:0] rate_lower_limit;
  logic [15:0] static_control;
  logic [15:0] dynamic_control;
  logic [7:0]  monitor_status;
  logic        fault;
  logic [31:0] last_width;
  logic [31:0] last_period;

  int checks = 0;
  int errors = 0;

  laser_pulse_monitor #(.SYNC_STAGES(2), .ENABLE_BIT(0), .CLEAR_BIT(0)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .pulse_in                (pulse_in),
    .pulse_width_lower_limit (pulse_width_lower_limit),
    .pulse_width_upper_limit (pulse_width_upper_limit),
    .rate_lower_limit        (rate_lower_limit),
    .static_control          (static_control),
    .dynamic_control         (dynamic_control),
    .monitor_status          (monitor_status),
    .fault                   (fault),
    .last_width              (last_width),
    .last_period             (last_period)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int unsigned w;
    int unsigned l;
    bit          clr;
    logic [31:0] exp_w;
    logic [31:0] exp_p;
    logic [7:0]  exp_st;
  } vec_t;

  vec_t vecs[7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Drives pulse_in high for w sampled edges then low for l; optional 1-clk clear at start.
  task automatic drive_pulse(input int unsigned w, input int unsigned l, input bit clr);
    pulse_in = 1'b1;
    if (clr) dynamic_control = 16'h0001;
    @(negedge clk);
    dynamic_control = 16'h0000;
    repeat (w - 1) @(negedge clk);
    pulse_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // Disable, clear flags, re-enable: FSM back in IDLE so the next pulse is a first pulse.
  task automatic reidle();
    static_control  = 16'h0000;
    dynamic_control = 16'h0001;
    @(negedge clk);
    dynamic_control = 16'h0000;
    repeat (2) @(negedge clk);
    static_control = 16'h0001;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Rate limit scaled down from the 77824 default to keep the run short.
    vecs[0] = '{300, 1800, 1'b0, 32'd300, 32'd0,    8'h60};
    vecs[1] = '{256, 1744, 1'b0, 32'd256, 32'd2100, 8'h60};
    vecs[2] = '{255, 1745, 1'b0, 32'd255, 32'd2000, 8'h69};
    vecs[3] = '{341, 1600, 1'b1, 32'd341, 32'd2000, 8'h60};
    vecs[4] = '{300, 1700, 1'b0, 32'd300, 32'd1941, 8'h6C};
    vecs[5] = '{300, 1699, 1'b1, 32'd300, 32'd2000, 8'h60};
    vecs[6] = '{300, 100,  1'b0, 32'd300, 32'd1999, 8'h6C};

    rst                     = 1'b0;
    pulse_in                = 1'b0;
    pulse_width_lower_limit = 32'd256;
    pulse_width_upper_limit = 32'd341;
    rate_lower_limit        = 32'd2000;
    static_control          = 16'h0001;
    dynamic_control         = 16'h0000;

    repeat (3) @(negedge clk);
    check8("reset_status", monitor_status, 8'h00);
    check32("reset_fault", {31'd0, fault}, 32'd0);
    check32("reset_last_width", last_width, 32'd0);
    check32("reset_last_period", last_period, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check8("enabled_idle_status", monitor_status, 8'h20);

    for (int i = 0; i < 7; i++) begin
      drive_pulse(vecs[i].w, vecs[i].l, vecs[i].clr);
      check32($sformatf("vec%0d_last_width", i), last_width, vecs[i].exp_w);
      check32($sformatf("vec%0d_last_period", i), last_period, vecs[i].exp_p);
      check8($sformatf("vec%0d_status", i), monitor_status, vecs[i].exp_st);
    end

    // Stuck high: width_long exactly 342 cycles after pulse_s rises, first pulse not rate-checked.
    reidle();
    check8("reidle_status", monitor_status, 8'h20);
    pulse_in = 1'b1;
    repeat (343) @(negedge clk);
    check8("stuck_high_before", monitor_status, 8'h70);
    @(negedge clk);
    check8("stuck_high_long", monitor_status, 8'h7A);
    check32("stuck_high_fault", {31'd0, fault}, 32'd1);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);
    check32("stuck_high_last_width", last_width, 32'd344);
    check8("stuck_high_after_fall", monitor_status, 8'h6A);

    // Clear coincident with the fall of a short pulse: the new fault wins.
    reidle();
    pulse_in = 1'b1;
    repeat (255) @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dynamic_control = 16'h0001;
    @(negedge clk);
    dynamic_control = 16'h0000;
    check8("coincident_clear_flags", {4'h0, monitor_status[3:0]}, 8'h09);
    check32("coincident_clear_width", last_width, 32'd255);

    // One-clock clear drops the fault on the next clock.
    dynamic_control = 16'h0001;
    @(negedge clk);
    dynamic_control = 16'h0000;
    check32("clear_fault", {31'd0, fault}, 32'd0);
    check8("clear_flags", {4'h0, monitor_status[3:0]}, 8'h00);

    // Disable mid-pulse: short pulse produces no check and last_width holds.
    reidle();
    pulse_in = 1'b1;
    repeat (100) @(negedge clk);
    static_control = 16'h0000;
    repeat (10) @(negedge clk);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);
    check32("disable_last_width", last_width, 32'd255);
    check8("disable_status", monitor_status, 8'h00);
    static_control = 16'h0001;
    repeat (3) @(negedge clk);

    // Reset mid-pulse, then first pulse unchecked and second pulse rate-checked.
    pulse_in = 1'b1;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    #1;
    check8("midreset_status", monitor_status, 8'h00);
    check32("midreset_last_width", last_width, 32'd0);
    check32("midreset_last_period", last_period, 32'd0);
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    drive_pulse(300, 100, 1'b0);
    check32("post_reset_width", last_width, 32'd300);
    check32("post_reset_period", last_period, 32'd0);
    check8("post_reset_status", monitor_status, 8'h60);
    drive_pulse(256, 100, 1'b0);
    check32("post_reset_period2", last_period, 32'd400);
    check8("post_reset_status2", monitor_status, 8'h6C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
